// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared FSM state type, keypad map and seven-segment glyphs
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, CONFIRM, HELD, RELEASE} state_t;

   // Scan index (row*4 + column) to the legend printed on that key
   function automatic logic [3:0] keymap(input logic [3:0] idx);
      logic [3:0] hex;
      case (idx)
         4'd0:    hex = 4'h1;
         4'd1:    hex = 4'h2;
         4'd2:    hex = 4'h3;
         4'd3:    hex = 4'hA;
         4'd4:    hex = 4'h4;
         4'd5:    hex = 4'h5;
         4'd6:    hex = 4'h6;
         4'd7:    hex = 4'hB;
         4'd8:    hex = 4'h7;
         4'd9:    hex = 4'h8;
         4'd10:   hex = 4'h9;
         4'd11:   hex = 4'hC;
         4'd12:   hex = 4'hE;
         4'd13:   hex = 4'h0;
         4'd14:   hex = 4'hF;
         default: hex = 4'hD;
      endcase
      return hex;
   endfunction

   // Active-low segments, bit 0 = a .. bit 6 = g
   function automatic logic [6:0] hex_glyph(input logic [3:0] value);
      logic [6:0] seg;
      case (value)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/keypad_digit_mux.sv
// rtl/keypad_digit_mux.sv - time-multiplexed drive of the digit history onto one seven-segment display
module keypad_digit_mux
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int MUX_BITS   = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_off,
   output logic [6:0]              seven_seg_digit
);

   localparam int SEL_W = $clog2(NUM_DIGITS);

   logic [MUX_BITS-1:0] mux_cnt;
   logic [SEL_W-1:0]    sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         mux_cnt <= '0;
         sel     <= '0;
      end else begin
         mux_cnt <= mux_cnt + MUX_BITS'(1);
         // Explicit wrap so non-power-of-two digit counts never select a missing digit
         if (&mux_cnt) begin
            if (sel == SEL_W'(NUM_DIGITS - 1))
               sel <= '0;
            else
               sel <= sel + SEL_W'(1);
         end
      end
   end

   always_comb begin
      digit_off      = '1;
      digit_off[sel] = 1'b0;
      seven_seg_digit = hex_glyph(digits[{sel, 2'b00} +: 4]);
   end

endmodule

// File: rtl/keypad_entry_display.sv
// rtl/keypad_entry_display.sv - 4x4 keypad scanner with debounce, digit history and multiplexed display
module keypad_entry_display
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SCAN_DWELL    = 4,
   parameter int DEBOUNCE_BITS = 20,
   parameter int MUX_BITS      = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              col_values,
   output logic [3:0]              row_values,
   output logic                    key_valid,
   output logic [3:0]              key_hex,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_off,
   output logic [6:0]              seven_seg_digit
);

   localparam int DWELL_W = $clog2(SCAN_DWELL);

   state_t                   state;
   logic [3:0]               col_s1, col_s2;
   logic [3:0]               index;
   logic [3:0]               index_next;
   logic [DWELL_W-1:0]       dwell;
   logic [DEBOUNCE_BITS-1:0] deb;
   logic                     sample_now;
   logic                     pressed;

   assign index_next = index + 4'd1;
   assign sample_now = (dwell == DWELL_W'(SCAN_DWELL - 1));
   assign pressed    = col_s2[index[1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SCAN;
         index      <= 4'd0;
         row_values <= 4'b0001;
         col_s1     <= 4'd0;
         col_s2     <= 4'd0;
         dwell      <= '0;
         deb        <= '0;
         key_valid  <= 1'b0;
         key_hex    <= 4'd0;
         digits     <= '0;
      end else begin
         col_s1    <= col_values;
         col_s2    <= col_s1;
         key_valid <= 1'b0;
         dwell     <= sample_now ? '0 : dwell + DWELL_W'(1);
         deb       <= deb + DEBOUNCE_BITS'(1);
         case (state)
            SCAN: begin
               if (sample_now) begin
                  if (pressed) begin
                     state <= CONFIRM;
                     deb   <= '0;
                  end else begin
                     index      <= index_next;
                     row_values <= 4'b0001 << index_next[3:2];
                  end
               end
            end
            CONFIRM: begin
               // A released sample on the final count still wins over acceptance
               if (sample_now && !pressed) begin
                  state <= SCAN;
               end else if (&deb) begin
                  state     <= HELD;
                  key_valid <= 1'b1;
                  key_hex   <= keymap(index);
                  digits    <= {digits[4*NUM_DIGITS-5:0], keymap(index)};
               end
            end
            HELD: begin
               if (sample_now && !pressed) begin
                  state <= RELEASE;
                  deb   <= '0;
               end
            end
            RELEASE: begin
               if (sample_now && pressed) begin
                  state <= HELD;
               end else if (&deb) begin
                  state      <= SCAN;
                  index      <= index_next;
                  row_values <= 4'b0001 << index_next[3:2];
                  dwell      <= '0;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

   keypad_digit_mux #(
      .NUM_DIGITS (NUM_DIGITS),
      .MUX_BITS   (MUX_BITS)
   ) u_digit_mux (
      .clk             (clk),
      .reset           (reset),
      .digits          (digits),
      .digit_off       (digit_off),
      .seven_seg_digit (seven_seg_digit)
   );

endmodule

// File: doc/keypad_entry_display.md
KEYPAD_ENTRY_DISPLAY -- requirements
Module: keypad_entry_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning display/history digits (legal 2..8).
REQ-002 SHALL have parameter SCAN_DWELL, default 4, meaning clk cycles per key position (legal 3..255).
REQ-003 SHALL have parameter DEBOUNCE_BITS, default 20, meaning press/release stable window of 2^DEBOUNCE_BITS cycles.
REQ-004 SHALL have parameter MUX_BITS, default 15, meaning each digit is lit for 2^MUX_BITS cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port col_values, input, 4 bits: raw asynchronous keypad columns, 1 = pressed.
REQ-008 SHALL have port row_values, output, 4 bits: registered one-hot row drive, with undriven rows at 0.
REQ-009 SHALL have port key_valid, output, 1 bit: one-cycle pulse per accepted press.
REQ-010 SHALL have port key_hex, output, 4 bits: hex value of the last accepted key.
REQ-011 SHALL have port digits, output, 4*NUM_DIGITS bits: history, with nibble 0 holding the newest key.
REQ-012 SHALL have port digit_off, output, NUM_DIGITS bits: active-high blanking with exactly one bit low.
REQ-013 SHALL have port seven_seg_digit, output, 7 bits: active-low segments, bit 0 = a through bit 6 = g.

Function
REQ-014 SHALL have a scan index 0..15 that advances every SCAN_DWELL cycles and wraps 15->0, but only in state SCAN.
REQ-015 SHALL drive row_values one-hot on index[3:2]; the sensed column is index[1:0].
REQ-016 SHALL pass col_values through a 2-flop synchronizer and sample the selected column only on the last dwell cycle.
REQ-017 SHALL map index to hex as 0..F -> 1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D.
REQ-018 SHALL implement the FSM states SCAN, CONFIRM, HELD and RELEASE.
REQ-019 SHALL transition SCAN->CONFIRM on a pressed sample; the index then freezes and the debounce counter clears.
REQ-020 SHALL, in CONFIRM, count while each sample reads pressed, return to SCAN on any released sample with no event, and go to HELD on counter all-ones.
REQ-021 SHALL, on the CONFIRM->HELD edge, register key_valid=1 and key_hex, and shift digits left by one nibble (nibble 0 = new key, top nibble discarded); all updates are visible the cycle after the edge.
REQ-022 SHALL go HELD->RELEASE on a released sample, with the counter cleared.
REQ-023 SHALL, in RELEASE, return to HELD on a pressed sample (no event), and go to SCAN on counter all-ones, with the index advancing from the held key.
REQ-024 SHALL ignore other keys while in CONFIRM, HELD or RELEASE; with multiple keys pressed in SCAN, the first index reached wins.
REQ-025 SHALL keep key_valid low in all cycles except the REQ-021 cycle, with no event on repeat or bounce.
REQ-026 SHALL use a display counter with MUX_BITS low bits; the digit select steps 0..NUM_DIGITS-1 and wraps to 0 for any NUM_DIGITS, power of 2 or not.
REQ-027 SHALL clear digit_off[sel] and set all other bits; seven_seg_digit is the glyph of nibble sel, combinational from registered state.

Reset
REQ-028 SHALL on reset apply: state=SCAN, index=0, row_values=4'b0001, synchronizer=0, counters=0.
REQ-029 SHALL on reset apply: key_valid=0, key_hex=0, digits=all 0, select=0, digit_off=all ones except bit 0.
REQ-030 SHALL treat reset asserted mid-CONFIRM, HELD or RELEASE as aborting the press with no event; reset SHALL take priority over every other update.

Structure
REQ-031 SHALL place the following in shared package keypad_pkg: the FSM state enum, the 16-entry keymap function, and the standard active-low hex glyph function.
REQ-032 SHALL implement the display multiplexer (REQ-026..027) as sub-module keypad_digit_mux, parameterised by NUM_DIGITS and MUX_BITS.

Verification
Benches SHALL use NUM_DIGITS=4, SCAN_DWELL=4, DEBOUNCE_BITS=3 and MUX_BITS=2.
REQ-033 SHALL check: reset, then idle 200 cycles -> row_values cycles 0001,0010,0100,1000 every 16 cycles, key_valid never 1, digits=16'h0000.
REQ-034 SHALL check: press index 5 until accepted, then release -> exactly one key_valid pulse, key_hex=5, digits=16'h0005.
REQ-035 SHALL check: keys 1,2,3,A,4 entered in sequence -> digits=16'h23A4 (1 discarded) after five pulses.
REQ-036 SHALL check: press index 9 with a one-sample release glitch in CONFIRM -> no pulse; after a stable press, one pulse with key_hex=8.
REQ-037 SHALL check: hold index 13, glitch released in RELEASE, re-press, also press index 0 -> one pulse total with key_hex=0, and no event for index 0.
REQ-038 SHALL check: assert reset while in HELD -> digits unchanged from reset value, state SCAN next cycle, no pulse.
